morse_symbol_decoder: RTL and testbench

- Consumes the 1 ms tick from the game's millisecond timer chain and the debounced key input.
- Times each key press to classify it as a dot or a dash, and times idle gaps to detect the end of a letter.
- Emits per-symbol pulses and a packed letter code to the game-control FSM, which compares it against the ROM target while the seconds timeout runs.

---
 rtl/morse_pkg.sv | 19 +
 rtl/ms_duration_counter.sv | 35 +++
 rtl/morse_symbol_decoder.sv | 124 ++++++++++++
 tb/tb_morse_symbol_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse decoder types and constants, also used by game control and the ROM compare.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } morseState_t;

  localparam int unsigned DASH_MS_DEFAULT = 300;
  localparam int unsigned GAP_MS_DEFAULT  = 1000;
  localparam int unsigned MAX_SYM_DEFAULT = 5;
  localparam int unsigned CNT_W_DEFAULT   = 12;
  localparam int unsigned LEN_W           = 3;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

endpackage

// File: rtl/ms_duration_counter.sv
// Millisecond-tick duration counter with synchronous load-zero, saturation and a registered threshold flag.
module ms_duration_counter #(
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned CMP_VAL = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             loadZero,
  output logic [CNT_W-1:0] count,
  output logic             reachedN
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CMP     = CNT_W'(CMP_VAL);

  logic [CNT_W-1:0] countNext;

  // Next count: zero on load, otherwise step on each tick until all-ones.
  always_comb begin
    countNext = count;
    if (rst || loadZero) begin
      countNext = '0;
    end else if (tick && (count != CNT_MAX)) begin
      countNext = count + CNT_W'(1);
    end
  end

  // Count and threshold flag are registered together so the flag tracks the count exactly.
  always_ff @(posedge clk) begin
    count    <= countNext;
    reachedN <= (countNext >= CMP);
  end

endmodule

// File: rtl/morse_symbol_decoder.sv
// Times key presses and idle gaps to emit dot/dash symbols and packed letter codes.
module morse_symbol_decoder
  import morse_pkg::*;
#(
  parameter int unsigned DASH_MS = DASH_MS_DEFAULT,
  parameter int unsigned GAP_MS  = GAP_MS_DEFAULT,
  parameter int unsigned MAX_SYM = MAX_SYM_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ms_tick,
  input  logic               key,
  input  logic               clear,
  output logic               sym_valid,
  output logic               sym_is_dash,
  output logic               letter_valid,
  output logic [MAX_SYM-1:0] letter_code,
  output logic [LEN_W-1:0]   letter_len,
  output logic               overflow,
  output logic               busy
);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_SYM);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_MS - 1);

  morseState_t        state;
  logic               keyQ;
  logic               rise;
  logic               fall;
  logic [MAX_SYM-1:0] code;
  logic [LEN_W-1:0]   len;
  logic               ovfFlag;
  logic [CNT_W-1:0]   count;
  logic               dashReached;
  logic               loadZero;
  logic               gapTimeout;
  logic               symClass;

  // Previous key sample; tracks the key through reset so a held key is not seen as a new press.
  always_ff @(posedge clk) begin
    keyQ <= key;
  end

  assign rise       = key & ~keyQ;
  assign fall       = ~key & keyQ;
  assign gapTimeout = ms_tick & (count == GAP_LAST);
  assign symClass   = dashReached ? SYM_DASH : SYM_DOT;
  assign loadZero   = clear
                    | (state == IDLE)
                    | ((state == PRESS) & fall)
                    | ((state == GAP) & rise);

  ms_duration_counter #(
    .CNT_W  (CNT_W),
    .CMP_VAL(DASH_MS)
  ) u_durationCounter (
    .clk     (clk),
    .rst     (rst),
    .tick    (ms_tick),
    .loadZero(loadZero),
    .count   (count),
    .reachedN(dashReached)
  );

  // Letter-assembly FSM with registered symbol and letter outputs.
  always_ff @(posedge clk) begin
    sym_valid    <= 1'b0;
    letter_valid <= 1'b0;
    if (rst || clear) begin
      state       <= IDLE;
      code        <= '0;
      len         <= '0;
      ovfFlag     <= 1'b0;
      sym_is_dash <= 1'b0;
      letter_code <= '0;
      letter_len  <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS;
            busy  <= 1'b1;
          end
        end
        PRESS: begin
          if (fall) begin
            state <= GAP;
            if (len < MAX_LEN) begin
              code[len]   <= symClass;
              len         <= len + LEN_W'(1);
              sym_valid   <= 1'b1;
              sym_is_dash <= symClass;
            end else begin
              ovfFlag <= 1'b1;
            end
          end
        end
        GAP: begin
          if (rise) begin
            state <= PRESS;
          end else if (gapTimeout) begin
            letter_valid <= 1'b1;
            letter_code  <= code;
            letter_len   <= len;
            overflow     <= ovfFlag;
            code         <= '0;
            len          <= '0;
            ovfFlag      <= 1'b0;
            state        <= IDLE;
            busy         <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed and randomized checks of the Morse symbol decoder against a press/gap duration model.
module tb_morse_symbol_decoder;

  localparam int unsigned DASH = 3;
  localparam int unsigned GAPT = 10;
  localparam int unsigned MAXS = 5;

  logic       clk = 1'b0;
  logic       rst, msTick, key, clear;
  logic       sym_valid, sym_is_dash, letter_valid, overflow, busy;
  logic [4:0] letter_code;
  logic [2:0] letter_len;

  int vectors = 0;
  int miscompares = 0;
  int phase = 0;
  int symCnt = 0, letCnt = 0;
  int expSymCnt = 0, expLetCnt = 0;

  // Reference letter under construction
  logic [4:0] mCode = '0;
  int         mLen = 0;
  logic       mOvf = 1'b0;

  morse_symbol_decoder #(
    .DASH_MS(DASH), .GAP_MS(GAPT), .MAX_SYM(MAXS), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ms_tick(msTick), .key(key), .clear(clear),
    .sym_valid(sym_valid), .sym_is_dash(sym_is_dash), .letter_valid(letter_valid),
    .letter_code(letter_code), .letter_len(letter_len), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (sym_valid === 1'b1) symCnt++;
    if (letter_valid === 1'b1) letCnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; ms_tick every 4th clock
  task automatic cycle();
    msTick = (phase == 0);
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
  endtask

  task automatic idleTicks(input int g);
    int c = 0;
    while (c < g) begin
      bit t;
      t = (phase == 0);
      cycle();
      if (t) c++;
    end
  endtask

  // Press held for exactly n counted ticks, then released
  task automatic press(input int n);
    bit dash;
    key = 1'b1;
    cycle();
    chk("busyOnRise", 32'(busy), 32'(1));
    chk("noLetterOnRise", 32'(letter_valid), 32'(0));
    idleTicks(n);
    key = 1'b0;
    cycle();
    dash = (n >= int'(DASH));
    if (mLen < int'(MAXS)) begin
      chk("symValid", 32'(sym_valid), 32'(1));
      chk("symIsDash", 32'(sym_is_dash), 32'(dash));
      mCode[mLen] = dash;
      mLen++;
      expSymCnt++;
    end else begin
      chk("symDropped", 32'(sym_valid), 32'(0));
      mOvf = 1'b1;
    end
  endtask

  task automatic letterEnd();
    logic [4:0] c;
    idleTicks(GAPT);
    chk("letterValid", 32'(letter_valid), 32'(1));
    chk("letterCode", 32'(letter_code), 32'(mCode));
    chk("letterLen", 32'(letter_len), 32'(mLen));
    chk("letterOvf", 32'(overflow), 32'(mOvf));
    expLetCnt++;
    c = mCode;
    mCode = '0; mLen = 0; mOvf = 1'b0;
    cycle();
    chk("letterPulseEnd", 32'(letter_valid), 32'(0));
    chk("letterCodeHold", 32'(letter_code), 32'(c));
    chk("busyAfterLetter", 32'(busy), 32'(0));
  endtask

  task automatic checkCounts(input string tag);
    chk({tag, "_symCount"}, 32'(symCnt), 32'(expSymCnt));
    chk({tag, "_letterCount"}, 32'(letCnt), 32'(expLetCnt));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; key = 1'b0; msTick = 1'b0;

    // Reset with key toggling
    for (int i = 0; i < 3; i++) begin
      key = (i % 2 == 0);
      cycle();
      chk("resetOutputs",
          32'({sym_valid, sym_is_dash, letter_valid, letter_code, letter_len, overflow, busy}),
          32'(0));
    end
    rst = 1'b0;
    repeat (8) cycle();
    chk("heldKeyIdle", 32'(busy), 32'(0));
    key = 1'b0;
    cycle();
    checkCounts("reset");

    // Letter A: dot then dash
    press(2); idleTicks(2); press(5);
    letterEnd();
    chk("A_code", 32'(letter_code), 32'(5'b00010));
    chk("A_len", 32'(letter_len), 32'(2));
    chk("A_ovf", 32'(overflow), 32'(0));
    checkCounts("A");

    // Classification boundaries: 3 ticks dash, 2 dot, 0 dot
    press(3); idleTicks(3); press(2); idleTicks(3); press(0);
    letterEnd();
    chk("bound_code", 32'(letter_code), 32'(5'b00001));
    chk("bound_len", 32'(letter_len), 32'(3));
    checkCounts("bound");

    // Long press beyond counter range stays a dash
    press(20);
    letterEnd();
    chk("sat_code", 32'(letter_code), 32'(5'b00001));
    checkCounts("sat");

    // Rise coincident with the final gap tick continues the letter
    press(1);
    idleTicks(GAPT - 1);
    while (phase != 0) cycle();
    press(4);
    letterEnd();
    chk("coinc_len", 32'(letter_len), 32'(2));
    chk("coinc_code", 32'(letter_code), 32'(5'b00010));
    checkCounts("coinc");

    // Six dots overflow a five-symbol letter
    for (int i = 0; i < 6; i++) begin
      press(1);
      if (i < 5) idleTicks(2);
    end
    letterEnd();
    chk("ovf_code", 32'(letter_code), 32'(5'b00000));
    chk("ovf_len", 32'(letter_len), 32'(5));
    chk("ovf_flag", 32'(overflow), 32'(1));
    checkCounts("ovf");

    // Clear mid-press after two symbols
    press(2); idleTicks(2); press(5); idleTicks(1);
    key = 1'b1;
    cycle();
    idleTicks(2);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clearBusy", 32'(busy), 32'(0));
    chk("clearOutputs", 32'({letter_code, letter_len, overflow}), 32'(0));
    key = 1'b0;
    cycle();
    idleTicks(GAPT + 2);
    mCode = '0; mLen = 0; mOvf = 1'b0;
    checkCounts("clear");
    press(4); idleTicks(1); press(0);
    letterEnd();
    chk("postClear_code", 32'(letter_code), 32'(5'b00001));
    chk("postClear_len", 32'(letter_len), 32'(2));
    checkCounts("postClear");

    // Randomized letters
    for (int l = 0; l < 8; l++) begin
      int np;
      np = int'($urandom_range(1, 7));
      for (int p = 0; p < np; p++) begin
        press(int'($urandom_range(0, 6)));
        if (p < np - 1) idleTicks(int'($urandom_range(0, 8)));
      end
      letterEnd();
    end
    checkCounts("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
